// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with whole-line fills over a
// level request/acknowledge memory handshake and hit/miss performance counters.
module icache #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_N,
  input  logic                   readM1,
  input  logic [WORD_SIZE-1:0]   address1,
  output logic [WORD_SIZE-1:0]   data1,
  output logic                   i_ready,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [WORD_SIZE-1:0]   mem_addr,
  input  logic                   mem_ack,
  input  logic [4*WORD_SIZE-1:0] mem_line,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                         state;
  logic [LINES-1:0]               valid;
  logic [TAG_BITS-1:0]            tags  [LINES];
  logic [3:0][WORD_SIZE-1:0]      lines [LINES];

  logic [1:0]            cur_off;
  logic [INDEX_BITS-1:0] cur_idx;
  logic [TAG_BITS-1:0]   cur_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;

  assign cur_off  = address1[1:0];
  assign cur_idx  = address1[INDEX_BITS+1:2];
  assign cur_tag  = address1[WORD_SIZE-1:INDEX_BITS+2];
  assign fill_idx = mem_addr[INDEX_BITS+1:2];
  assign fill_tag = mem_addr[WORD_SIZE-1:INDEX_BITS+2];
  assign hit      = valid[cur_idx] && (tags[cur_idx] == cur_tag);

  always_comb begin
    data1   = '0;
    i_ready = 1'b0;
    if (state == IDLE) begin
      if (!readM1) begin
        i_ready = 1'b1;
      end else if (hit) begin
        i_ready = 1'b1;
        data1   = lines[cur_idx][cur_off];
      end
    end
  end

  // Flush clears valid first so that an in-flight fill landing on the same edge still installs.
  always_ff @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) begin
      state      <= IDLE;
      valid      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int i = 0; i < LINES; i++) begin
        tags[i]  <= '0;
        lines[i] <= '0;
      end
    end else begin
      if (flush)
        valid <= '0;
      case (state)
        IDLE: begin
          if (readM1) begin
            if (hit) begin
              hit_count <= hit_count + 16'd1;
            end else begin
              miss_count <= miss_count + 16'd1;
              mem_addr   <= {cur_tag, cur_idx, 2'b00};
              mem_req    <= 1'b1;
              state      <= MISS;
            end
          end
        end
        MISS: begin
          if (mem_ack) begin
            lines[fill_idx] <= mem_line;
            tags[fill_idx]  <= fill_tag;
            valid[fill_idx] <= 1'b1;
            mem_req         <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_icache;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        readM1;
  logic [15:0] address1;
  logic [15:0] data1;
  logic        i_ready;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_line;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] LINE_A = 64'h4444_3333_2222_1111;
  localparam logic [63:0] LINE_B = 64'hBBBB_AAAA_9999_8888;
  localparam logic [63:0] LINE_C = 64'hDDDD_CCCC_EEEE_FFFF;
  localparam logic [63:0] LINE_D = 64'h7777_6666_5555_4444;
  localparam logic [63:0] LINE_E = 64'h0E0E_0D0D_0C0C_0B0B;

  icache dut (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .readM1     (readM1),
    .address1   (address1),
    .data1      (data1),
    .i_ready    (i_ready),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_line   (mem_line),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [15:0] addr, input logic fl,
                               input logic ack, input logic [63:0] line);
    readM1   = rd;
    address1 = addr;
    flush    = fl;
    mem_ack  = ack;
    mem_line = line;
  endtask

  // One full miss on addr: detect cycle, L MISS cycles with ack in the last,
  // then the re-presented request must hit. Optional flush in MISS cycle flushAt.
  task automatic doMiss(input logic [15:0] addr, input logic [63:0] line, input int L,
                        input logic [15:0] expAddr, input int flushAt);
    @(negedge Clk);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("miss_detect_ready", i_ready, 1'b0);
    for (int i = 1; i <= L; i++) begin
      @(negedge Clk);
      applyStimulus(1'b1, addr, (i == flushAt), (i == L), (i == L) ? line : 64'h0);
      #1;
      checkOutput("miss_req", mem_req, 1'b1);
      checkOutput("miss_addr", mem_addr, expAddr);
      checkOutput("miss_ready", i_ready, 1'b0);
      checkOutput("miss_data", data1, 16'h0000);
    end
    @(negedge Clk);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("fill_ready", i_ready, 1'b1);
    checkOutput("fill_req_drop", mem_req, 1'b0);
  endtask

  task automatic doFetch(input logic [15:0] addr, input logic [15:0] expData);
    @(negedge Clk);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("hit_ready", i_ready, 1'b1);
    checkOutput("hit_data", data1, expData);
  endtask

  task automatic checkCounts(input logic [15:0] expHit, input logic [15:0] expMiss);
    @(negedge Clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("hit_count", hit_count, expHit);
    checkOutput("miss_count", miss_count, expMiss);
    checkOutput("idle_ready", i_ready, 1'b1);
    checkOutput("idle_data", data1, 16'h0000);
  endtask

  initial begin
    Reset_N = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 64'h0);
    repeat (2) @(negedge Clk);
    #1;
    checkOutput("rst_ready_idle", i_ready, 1'b1);
    checkOutput("rst_req", mem_req, 1'b0);
    checkOutput("rst_addr", mem_addr, 16'h0000);
    checkOutput("rst_hits", hit_count, 16'h0000);
    checkOutput("rst_misses", miss_count, 16'h0000);
    applyStimulus(1'b1, 16'h0005, 1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("rst_ready_read", i_ready, 1'b0);
    checkOutput("rst_data", data1, 16'h0000);
    @(negedge Clk);
    Reset_N = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 64'h0);

    // Cold miss, then spatial hits in the same line
    doMiss(16'h0005, LINE_A, 3, 16'h0004, 0);
    checkOutput("cold_data", data1, 16'h2222);
    doFetch(16'h0004, 16'h1111);
    checkOutput("cold_hits", hit_count, 16'd1);
    checkOutput("cold_misses", miss_count, 16'd1);
    doFetch(16'h0006, 16'h3333);
    doFetch(16'h0007, 16'h4444);
    checkCounts(16'd4, 16'd1);

    // Conflict on index 1 evicts and then re-fetches the original line
    doMiss(16'h0014, LINE_B, 1, 16'h0014, 0);
    checkOutput("conflict_data", data1, 16'h8888);
    doMiss(16'h0005, LINE_A, 2, 16'h0004, 0);
    checkOutput("refetch_data", data1, 16'h2222);
    checkCounts(16'd6, 16'd3);

    // Flush in IDLE still returns the same-cycle hit, then the line misses
    @(negedge Clk);
    applyStimulus(1'b1, 16'h0005, 1'b1, 1'b0, 64'h0);
    #1;
    checkOutput("flush_hit_ready", i_ready, 1'b1);
    checkOutput("flush_hit_data", data1, 16'h2222);
    doMiss(16'h0004, LINE_A, 2, 16'h0004, 0);
    checkOutput("post_flush_data", data1, 16'h1111);
    checkCounts(16'd8, 16'd4);

    // Flush during MISS: the fill still installs a valid line
    doMiss(16'h000C, LINE_C, 3, 16'h000C, 2);
    checkOutput("flush_miss_data", data1, 16'hFFFF);
    doFetch(16'h000D, 16'hEEEE);
    checkCounts(16'd10, 16'd5);

    // Address change mid-miss: fill still targets 0x0008
    @(negedge Clk);
    applyStimulus(1'b1, 16'h0008, 1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("chg_detect", i_ready, 1'b0);
    @(negedge Clk);
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("chg_addr", mem_addr, 16'h0008);
    checkOutput("chg_ready", i_ready, 1'b0);
    @(negedge Clk);
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b1, LINE_D);
    #1;
    checkOutput("chg_addr_ack", mem_addr, 16'h0008);
    doFetch(16'h0008, 16'h4444);
    doMiss(16'h0020, LINE_E, 1, 16'h0020, 0);
    checkOutput("chg_second_data", data1, 16'h0B0B);
    checkCounts(16'd12, 16'd7);

    // Reset while a fill is outstanding; the late ack must be ignored
    @(negedge Clk);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 64'h0);
    @(negedge Clk);
    #1;
    checkOutput("rstmiss_req_before", mem_req, 1'b1);
    Reset_N = 1'b1;
    #1;
    checkOutput("rstmiss_req", mem_req, 1'b0);
    checkOutput("rstmiss_hits", hit_count, 16'h0000);
    checkOutput("rstmiss_misses", miss_count, 16'h0000);
    @(negedge Clk);
    Reset_N = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, LINE_D);
    @(negedge Clk);
    applyStimulus(1'b1, 16'h0008, 1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("late_ack_ready", i_ready, 1'b0);
    checkOutput("late_ack_data", data1, 16'h0000);
    @(negedge Clk);
    #1;
    checkOutput("late_ack_req", mem_req, 1'b1);
    checkOutput("late_ack_misses", miss_count, 16'd1);
    checkOutput("late_ack_hits", hit_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the CPU fetch port (`readM1`/`address1`/`data1`) and the multi-cycle instruction memory. Hits return the instruction in the same cycle. A miss stalls fetch, fetches a whole 4-word line from memory with a level request/acknowledge handshake, installs it, and then completes the access. Two 16-bit counters record hits and misses for performance runs.

## Interface
- `WORD_SIZE`, 16, instruction/address width; other widths in this spec assume 16.
- `INDEX_BITS`, 2, number of lines = 2^INDEX_BITS; tag width = WORD_SIZE − INDEX_BITS − 2.
- `Clk`  in  1  single clock, rising edge.
- `Reset_N`  in  1  asynchronous, active-high reset. Despite the name, 1 = reset.
- `readM1`  in  1  CPU fetch request, level.
- `address1`  in  16  CPU fetch address (word address).
- `data1`  out  16  fetched instruction; 16'h0000 unless a hit is being returned.
- `i_ready`  out  1  1 = `data1` valid this cycle or no request pending; 0 = CPU must stall.
- `flush`  in  1  invalidate all lines at next edge.
- `mem_req`  out  1  line fill request, level, held until ack.
- `mem_addr`  out  16  line base address ({tag,index,2'b00}), stable while `mem_req`=1.
- `mem_ack`  in  1  one-cycle pulse; `mem_line` valid in the same cycle.
- `mem_line`  in  64  words 0..3 of the line; word k at bits [16k+15:16k].
- `hit_count`  out  16  hits counted since reset.
- `miss_count`  out  16  misses counted since reset.

## Operation
- Address split: offset = `address1`[1:0], index = `address1`[INDEX_BITS+1:2], tag = upper bits.
- Storage per line: valid bit, tag, 4×16 data. All storage is registered; lookup is combinational.
- State machine with two states:
  - IDLE: if `readM1`=1 and hit, then `data1` = selected word, `i_ready`=1, and `hit_count` increments. If `readM1`=1 and miss, then `i_ready`=0, the line base address is latched, `miss_count` increments, and the next state is MISS. If `readM1`=0, then `i_ready`=1 and `data1`=0.
  - MISS: `mem_req`=1, `mem_addr` = latched base, `i_ready`=0, `data1`=0. On an edge with `mem_ack`=1, `mem_line` is written to the latched index, the tag is set, valid is set to 1, and the next state is IDLE.
- The re-presented request after a fill hits and counts as a hit. A miss therefore increments both counters once.
- No abort: changes to `address1` or `readM1` during MISS are ignored, and the fill completes with the latched address.
- `flush`: at the edge, all valid bits clear. During MISS, the flush is applied first and the in-flight fill still installs its line as valid. Flush in IDLE does not block the same-cycle hit output; the lookup uses pre-edge state.
- Counters wrap modulo 2^16 without saturation.
- `mem_ack` while in IDLE is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all valid=0, tags/data=0, `mem_req`=0, `mem_addr`=0, `hit_count`=0, `miss_count`=0. Combinational outputs follow: `i_ready`=1 if `readM1`=0, else 0 (all misses); `data1`=0.
- Hit latency 0 cycles: data appears in the same cycle as `address1`.
- Miss: cycle 0 detects the miss (`i_ready`=0). Cycles 1..L hold `mem_req`=1, where L ≥ 1 is the cycle in which `mem_ack` arrives. Cycle L+1 is IDLE and hits. Total stall = L+1 cycles; minimum stall is 2 cycles when ack arrives in the first MISS cycle.
- `mem_req` drops the cycle after ack; a new miss cannot raise it again until one IDLE cycle has passed.
- Reset asserted mid-MISS: the fill is abandoned, `mem_req` drops immediately, and a late `mem_ack` is ignored.

## Test plan
- Cold miss: reset, then `readM1`=1, `address1`=16'h0005, ack after 3 MISS cycles with `mem_line`=64'h4444_3333_2222_1111. Required: `mem_addr`=16'h0004, `i_ready` low for 4 cycles, then `data1`=16'h2222, hit=1, miss=1.
- Spatial hits: after the above, fetch 16'h0004/6/7. Required: 16'h1111, 16'h3333, 16'h4444, each with `i_ready`=1 in the same cycle; hit=4.
- Conflict: fetch 16'h0014 (same index 1, tag differs). Required: miss, `mem_addr`=16'h0014, new line installed. Then fetch 16'h0005 misses again; miss count +2.
- Flush: line 0x0004 valid, pulse `flush`, then fetch 16'h0004. Required: miss (`i_ready`=0, `mem_req`=1). Also: flush during MISS, then after ack the line hits.
- Address change mid-miss: miss on 16'h0008, switch `address1` to 16'h0020 before ack. Required: fill uses `mem_addr`=16'h0008, then 16'h0020 misses separately.
- Reset mid-MISS: assert `Reset_N`=1 while `mem_req`=1. Required: `mem_req`=0 and both counters 0 immediately; an ack arriving later installs nothing (16'h0008 still misses).
